// File: rtl/arb_mux_reg.sv
// -----------------------------------------------------------------------------
// arb_mux_reg
//   N-channel valid/ready multiplexer with a registered output stage.
//   Requesters are arbitrated either by fixed priority (lowest index wins) or
//   round-robin (search starts at rr_ptr), selected at run time by 'mode'.
//   The winning channel's word is captured into the output register; the
//   output register reloads whenever it is empty or being drained, so a
//   continuously ready sink sees one word per cycle.
//
//   Optional feature (macro ARB_MUX_FORCE_EN): adds force_en / force_sel.
//   While force_en=1 only channel force_sel may win, mode is ignored and
//   rr_ptr is left alone.
//
// Parameters
//   WIDTH  data bits per channel
//   NCH    number of channels, power of two 2..16
//   IDX_W  channel index width, must equal log2(NCH)
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   mode       0 = fixed priority, 1 = round-robin
//   in_valid   per-channel request
//   in_data    flat channel data, channel k at [k*WIDTH +: WIDTH]
//   in_ready   one-hot accept strobe (combinational)
//   out_valid  output register holds a word
//   out_data   registered selected data
//   out_sel    index of the channel that supplied out_data
//   out_ready  sink accepts out_data this cycle
//   force_en   (ARB_MUX_FORCE_EN only) restrict eligibility to force_sel
//   force_sel  (ARB_MUX_FORCE_EN only) forced channel index
// -----------------------------------------------------------------------------
module arb_mux_reg #(
  parameter int WIDTH = 16,
  parameter int NCH   = 8,
  parameter int IDX_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode,
  input  logic [NCH-1:0]         in_valid,
  input  logic [NCH*WIDTH-1:0]   in_data,
  output logic [NCH-1:0]         in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [IDX_W-1:0]       out_sel,
  input  logic                   out_ready
`ifdef ARB_MUX_FORCE_EN
  ,
  input  logic                   force_en,
  input  logic [IDX_W-1:0]       force_sel
`endif
);

  logic                 load_p0;
  logic                 forced_p0;
  logic [NCH-1:0]       elig_p0;
  logic [IDX_W-1:0]     start_p0;
  logic [IDX_W-1:0]     idx_p0;
  logic                 vld_p0;
  logic [IDX_W-1:0]     grant_p0;
  logic [WIDTH-1:0]     data_p0;
  logic [IDX_W-1:0]     rr_ptr;

  // ---- stage p0: combinational arbitration ---------------------------------

  // The output register can take a new word when it is empty or its current
  // word leaves this cycle.
  assign load_p0 = !out_valid || out_ready;

  always_comb begin
    forced_p0 = 1'b0;
    elig_p0   = in_valid;
`ifdef ARB_MUX_FORCE_EN
    forced_p0 = force_en;
    if (force_en) begin
      elig_p0 = in_valid & (NCH'(1) << force_sel);
    end
`endif
  end

  // A forced search only has one eligible bit, so starting at 0 is enough.
  assign start_p0 = (mode && !forced_p0) ? rr_ptr : '0;

  // Rotating search: the IDX_W-bit addition wraps modulo NCH because NCH is
  // a power of two.
  always_comb begin
    vld_p0   = 1'b0;
    grant_p0 = '0;
    idx_p0   = '0;
    for (int i = 0; i < NCH; i++) begin
      idx_p0 = start_p0 + IDX_W'(i);
      if (!vld_p0 && elig_p0[idx_p0]) begin
        vld_p0   = 1'b1;
        grant_p0 = idx_p0;
      end
    end
  end

  always_comb begin
    data_p0 = '0;
    for (int k = 0; k < NCH; k++) begin
      if (grant_p0 == IDX_W'(k)) begin
        data_p0 = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready = (!rst && load_p0 && vld_p0) ? (NCH'(1) << grant_p0) : '0;

  // ---- stage p1: output register and round-robin pointer -------------------

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= '0;
    end else if (load_p0) begin
      if (vld_p0) begin
        out_valid <= 1'b1;
        out_data  <= data_p0;
        out_sel   <= grant_p0;
        // Only round-robin grants advance the pointer; fixed-priority and
        // forced grants leave the rotation where it was.
        if (mode && !forced_p0) begin
          rr_ptr <= grant_p0 + IDX_W'(1);
        end
      end else begin
        // Drained with nothing new: data and index keep their last values.
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux_reg.sv
module tb_arb_mux_reg;

  localparam int WIDTH = 16;
  localparam int NCH   = 8;
  localparam int IDX_W = 3;

  logic                 clk;
  logic                 rst;
  logic                 mode;
  logic [NCH-1:0]       in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [IDX_W-1:0]     out_sel;
  logic                 out_ready;
`ifdef ARB_MUX_FORCE_EN
  logic                 force_en;
  logic [IDX_W-1:0]     force_sel;
`endif

  // reference model state: what the output register should hold
  logic                 m_valid;
  logic [WIDTH-1:0]     m_data;
  logic [IDX_W-1:0]     m_sel;
  int                   m_ptr;

  int n_vec;
  int n_err;

  arb_mux_reg #(.WIDTH(WIDTH), .NCH(NCH), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
`ifdef ARB_MUX_FORCE_EN
    ,
    .force_en  (force_en),
    .force_sel (force_sel)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic cur_fe();
`ifdef ARB_MUX_FORCE_EN
    return force_en;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int cur_fs();
`ifdef ARB_MUX_FORCE_EN
    return int'(force_sel);
`else
    return 0;
`endif
  endfunction

  // Winner by the arbitration rules; -1 when nobody is eligible.
  function automatic int pick(input logic [NCH-1:0] v, input logic md,
                              input int ptr, input logic fe, input int fs);
    int start;
    if (fe) return v[fs] ? fs : -1;
    start = md ? ptr : 0;
    for (int i = 0; i < NCH; i++) begin
      if (v[(start + i) % NCH]) return (start + i) % NCH;
    end
    return -1;
  endfunction

  function automatic logic [NCH-1:0] exp_ready();
    int g;
    logic [NCH-1:0] one;
    one = 1;
    g = pick(in_valid, mode, m_ptr, cur_fe(), cur_fs());
    if (rst || !(!m_valid || out_ready) || g < 0) return '0;
    return one << g;
  endfunction

  task automatic rand_data();
    for (int k = 0; k < NCH; k++) in_data[k*WIDTH +: WIDTH] = WIDTH'($urandom);
  endtask

  // Advance one clock edge and update the model from the inputs present now.
  task automatic tick();
    int g;
    logic ld;
    g  = pick(in_valid, mode, m_ptr, cur_fe(), cur_fs());
    ld = !m_valid || out_ready;
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_sel = '0; m_ptr = 0;
    end else if (ld) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g*WIDTH +: WIDTH];
        m_sel   = g[IDX_W-1:0];
        if (mode && !cur_fe()) m_ptr = (g + 1) % NCH;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; in_valid = '1; out_ready = 1'b1; rand_data();
    for (int c = 0; c < 2; c++) begin
      tick();
      #1;
      n_vec++;
      if (in_ready !== '0) begin
        n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
      end
      n_vec++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== '0) begin
        n_err++;
        $display("FAIL reset_outputs: got v=%b d=%h s=%0d want 0/0/0", out_valid, out_data, out_sel);
      end
    end
    // first grant after release, both modes
    for (int md = 0; md < 2; md++) begin
      rst = 1'b1; tick();
      rst = 1'b0; mode = md[0]; in_valid = '1; rand_data();
      #1;
      n_vec++;
      if (in_ready !== 8'b0000_0001) begin
        n_err++; $display("FAIL reset_first_grant mode%0d: got %b want 00000001", md, in_ready);
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_sel !== 3'd0 || out_data !== in_data[0 +: WIDTH]) begin
        n_err++;
        $display("FAIL reset_first_word mode%0d: got v=%b s=%0d d=%h want 1/0/%h",
                 md, out_valid, out_sel, out_data, in_data[0 +: WIDTH]);
      end
    end
  endtask

  task automatic test_fixed_priority();
    logic [WIDTH-1:0] d2;
    rst = 1'b0; mode = 1'b0; in_valid = 8'b1010_0100; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      rand_data();
      d2 = in_data[2*WIDTH +: WIDTH];
      #1;
      n_vec++;
      if (in_ready !== 8'b0000_0100) begin
        n_err++; $display("FAIL fixed_in_ready: got %b want 00000100", in_ready);
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_sel !== 3'd2 || out_data !== d2) begin
        n_err++;
        $display("FAIL fixed_out: got v=%b s=%0d d=%h want 1/2/%h", out_valid, out_sel, out_data, d2);
      end
    end
  endtask

  task automatic test_rr_wrap();
    rst = 1'b1; tick();
    rst = 1'b0; mode = 1'b1; in_valid = '1; out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      rand_data();
      #1;
      n_vec++;
      if (in_ready !== exp_ready()) begin
        n_err++; $display("FAIL rr_in_ready step%0d: got %b want %b", c, in_ready, exp_ready());
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || int'(out_sel) != c % NCH || out_data !== m_data) begin
        n_err++;
        $display("FAIL rr_sequence step%0d: got v=%b s=%0d d=%h want 1/%0d/%h",
                 c, out_valid, out_sel, out_data, c % NCH, m_data);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] held_d;
    logic [IDX_W-1:0] held_s;
    logic [WIDTH-1:0] d3;
    rst = 1'b0; mode = 1'b0; in_valid = 8'b0000_1000; out_ready = 1'b1; rand_data();
    tick();
    held_d = m_data; held_s = m_sel;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      rand_data();
      #1;
      n_vec++;
      if (in_ready !== '0) begin
        n_err++; $display("FAIL bp_in_ready cyc%0d: got %b want 0", c, in_ready);
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== held_d || out_sel !== held_s) begin
        n_err++;
        $display("FAIL bp_hold cyc%0d: got v=%b d=%h s=%0d want 1/%h/%0d",
                 c, out_valid, out_data, out_sel, held_d, held_s);
      end
    end
    out_ready = 1'b1; rand_data();
    d3 = in_data[3*WIDTH +: WIDTH];
    #1;
    n_vec++;
    if (in_ready !== 8'b0000_1000) begin
      n_err++; $display("FAIL bp_release_ready: got %b want 00001000", in_ready);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_sel !== 3'd3 || out_data !== d3) begin
      n_err++;
      $display("FAIL bp_no_bubble: got v=%b s=%0d d=%h want 1/3/%h", out_valid, out_sel, out_data, d3);
    end
  endtask

  task automatic test_idle_drain();
    logic [WIDTH-1:0] d6;
    rst = 1'b0; mode = 1'b1; in_valid = 8'b0100_0000; out_ready = 1'b1; rand_data();
    d6 = in_data[6*WIDTH +: WIDTH];
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_sel !== 3'd6 || out_data !== d6) begin
      n_err++; $display("FAIL drain_load: got v=%b s=%0d d=%h want 1/6/%h", out_valid, out_sel, out_data, d6);
    end
    in_valid = '0; rand_data();
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || out_sel !== 3'd6 || out_data !== d6) begin
      n_err++; $display("FAIL drain_empty: got v=%b s=%0d d=%h want 0/6/%h", out_valid, out_sel, out_data, d6);
    end
  endtask

`ifdef ARB_MUX_FORCE_EN
  task automatic test_force();
    rst = 1'b1; force_en = 1'b0; force_sel = '0; tick();
    rst = 1'b0; mode = 1'b1; in_valid = '1; out_ready = 1'b1;
    force_en = 1'b1; force_sel = 3'd5;
    for (int c = 0; c < 4; c++) begin
      rand_data();
      #1;
      n_vec++;
      if (in_ready !== 8'b0010_0000) begin
        n_err++; $display("FAIL force_in_ready: got %b want 00100000", in_ready);
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_sel !== 3'd5 || out_data !== m_data) begin
        n_err++; $display("FAIL force_out: got v=%b s=%0d d=%h want 1/5/%h", out_valid, out_sel, out_data, m_data);
      end
    end
    // pointer untouched by forced grants, so round-robin resumes at ch0
    force_en = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 8'b0000_0001) begin
      n_err++; $display("FAIL force_ptr_kept: got %b want 00000001", in_ready);
    end
    force_en = 1'b1; in_valid = 8'b1101_1111;
    #1;
    n_vec++;
    if (in_ready !== '0) begin
      n_err++; $display("FAIL force_absent_ready: got %b want 0", in_ready);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL force_absent_valid: got %b want 0", out_valid);
    end
    force_en = 1'b0;
  endtask
`endif

  task automatic test_random();
    rst = 1'b1; tick();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 39) == 0);
      mode      = 1'($urandom);
      in_valid  = NCH'($urandom) & NCH'($urandom | $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef ARB_MUX_FORCE_EN
      force_en  = ($urandom_range(0, 5) == 0);
      force_sel = IDX_W'($urandom);
`endif
      rand_data();
      #1;
      n_vec++;
      if (in_ready !== exp_ready()) begin
        n_err++; $display("FAIL rand_in_ready cyc%0d: got %b want %b", c, in_ready, exp_ready());
      end
      tick();
      n_vec++;
      if (out_valid !== m_valid || out_data !== m_data || out_sel !== m_sel) begin
        n_err++;
        $display("FAIL rand_out cyc%0d: got v=%b d=%h s=%0d want %b/%h/%0d",
                 c, out_valid, out_data, out_sel, m_valid, m_data, m_sel);
      end
    end
`ifdef ARB_MUX_FORCE_EN
    force_en = 1'b0;
`endif
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; mode = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
`ifdef ARB_MUX_FORCE_EN
    force_en = 1'b0; force_sel = '0;
`endif
    m_valid = 1'b0; m_data = '0; m_sel = '0; m_ptr = 0;
    @(posedge clk); #1;
    test_reset();
    test_fixed_priority();
    test_rr_wrap();
    test_backpressure();
    test_idle_drain();
`ifdef ARB_MUX_FORCE_EN
    test_force();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/arb_mux_reg.md
Name: arb_mux_reg

Overview:
- Parametrised successor of the combinational 2/4/8/16-to-1 data muxes.
- N-channel valid/ready multiplexer with a registered output stage.
- Arbitration is fixed-priority or round-robin, chosen at run time.
- Merges requesters in the pipeline onto one shared sink, e.g. interrupt/exception cause sources into CP0, or memory request sources into one bus port.

Parameters:
- WIDTH, 16, data bits per channel.
- NCH, 8, number of input channels; power of two, 2..16.
- IDX_W, 3, width of channel index; must equal log2(NCH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = fixed priority (lowest index wins), 1 = round-robin.
- in_valid  input  NCH  per-channel request.
- in_data  input  NCH*WIDTH  flat channel data; channel k at bits [k*WIDTH +: WIDTH].
- in_ready  output  NCH  one-hot accept strobe, combinational.
- out_valid  output  1  registered output holds a word.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  IDX_W  index of the channel that supplied out_data.
- out_ready  input  1  sink accepts out_data this cycle.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_sel=0, rr_ptr=0.
- While rst=1: in_ready=0 regardless of inputs.
- Reset mid-transfer discards the held word; no channel sees in_ready for it.
- load = !out_valid || out_ready. This gives full throughput: one word per cycle with out_ready held high.
- Grant, combinational, evaluated only when load=1 and rst=0:
  - mode 0: lowest k with in_valid[k]=1.
  - mode 1: first k with in_valid[k]=1, searching rr_ptr, rr_ptr+1, ... modulo NCH.
- in_ready[grant]=1 when load=1 and any in_valid is set; all other in_ready bits are 0. At most one bit is set.
- Edge with load=1 and a grant: out_data<=in_data[grant], out_sel<=grant, out_valid<=1. Latency is 1 cycle from the accepting edge.
- Edge with load=1 and no in_valid: out_valid<=0; out_data and out_sel hold their last values.
- Edge with load=0 (out_valid=1, out_ready=0): all output registers hold; in_ready=0 for every channel.
- rr_ptr update:
  - Changes only on a grant made with mode=1: rr_ptr <= (grant+1) mod NCH.
  - Wraps from NCH-1 to 0.
  - Unchanged by mode-0 grants.
- Mode change applies to the next arbitration. A word already in the output register is never dropped or reordered.
- Producers hold in_valid/in_data until they see in_ready. The block does not buffer unaccepted requests.
- Simultaneous out_ready=1 and a new grant in one cycle: old word consumed and new word loaded on the same edge (no bubble).
- With only one channel valid, that channel wins in both modes.

Optional Feature:
- Macro: ARB_MUX_FORCE_EN.
- Defined:
  - Adds ports force_en (input, 1) and force_sel (input, IDX_W).
  - When force_en=1, only channel force_sel is eligible; the mode setting is ignored.
  - rr_ptr does not change on forced grants.
  - If in_valid[force_sel]=0, no grant is made: out_valid<=0 when load=1, and all in_ready bits are 0.
- Undefined: ports absent; arbitration exactly as in Behaviour.

Test Plan:
- Reset: rst=1 for 2 cycles with all in_valid=1. Expect in_ready=0, out_valid=0, out_data=0, out_sel=0. On release, first grant is ch0 in both modes.
- Fixed priority: mode=0, in_valid=8'b1010_0100, out_ready=1. Expect ch2 granted every cycle, out_sel=2, out_data=in_data[2] one cycle after grant; ch5 and ch7 never get in_ready.
- Round-robin wrap: mode=1, all 8 valid, out_ready=1. Expect out_sel sequence 0,1,2,...,7,0. rr_ptr wraps from 7 to 0.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles while ch3 is valid. Expect out_data/out_sel stable and in_ready=0. On the cycle out_ready=1, in_ready[3]=1 and the new word appears next cycle with no bubble.
- Idle drain: single word from ch6, then in_valid=0 and out_ready=1. Expect out_valid to fall the cycle after consumption; out_sel stays 6.
- ARB_MUX_FORCE_EN: mode=1, all valid, force_en=1, force_sel=5. Expect only ch5 granted and rr_ptr unchanged. With in_valid[5]=0, expect out_valid=0 and all in_ready=0.
